// File: rtl/f2h_bridge_master_if.sv
// Command/response and Avalon-MM signal bundle for f2h_bridge_master.
// The master modport is the bridge's view; slave is the fabric-user/Avalon-slave side.
interface f2h_bridge_master_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 64
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [ADDRWIDTH-1:0]   cmd_address;
  logic [DATAWIDTH-1:0]   cmd_writedata;
  logic [DATAWIDTH/8-1:0] cmd_byteenable;
  logic                   rsp_valid;
  logic [DATAWIDTH-1:0]   rsp_readdata;
  logic                   rsp_error;
  logic [ADDRWIDTH-1:0]   avm_address;
  logic                   avm_read;
  logic                   avm_write;
  logic [DATAWIDTH-1:0]   avm_writedata;
  logic [DATAWIDTH/8-1:0] avm_byteenable;
  logic                   avm_burstcount;
  logic [DATAWIDTH-1:0]   avm_readdata;
  logic                   avm_readdatavalid;
  logic                   avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount
  );
endinterface

// File: rtl/f2h_bridge_master.sv
// Single-outstanding Avalon-MM master: fabric command/response port to an Avalon slave.
// Define F2H_TIMEOUT_EN to enable the watchdog that aborts stalled transactions.
module f2h_bridge_master #(
  parameter int ADDRWIDTH      = 32,
  parameter int DATAWIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  f2h_bridge_master_if.master bus
);
  localparam int BEW = DATAWIDTH / 8;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} state_t;

  state_t state, state_next;
  logic   is_write;
  logic   complete;
  logic   capture;
  logic   timeout;
  logic   err_next;

`ifdef F2H_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;

  // Held at zero in IDLE so it starts from zero on entry to CMD.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else if (state == CMD || state == RDWAIT) cnt <= cnt + 1'b1;
  end

  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err_next = (state_next == RESP) && !complete;
`else
  assign timeout  = 1'b0;
  assign err_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Completion takes priority over a coincident watchdog expiry.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) state_next = CMD;
      CMD: begin
        if (!bus.avm_waitrequest && (is_write || bus.avm_readdatavalid)) begin
          complete = 1'b1;
          capture  = !is_write;
        end
        if (complete || timeout)      state_next = RESP;
        else if (!bus.avm_waitrequest) state_next = RDWAIT;
      end
      RDWAIT: begin
        complete = bus.avm_readdatavalid;
        capture  = bus.avm_readdatavalid;
        if (complete || timeout) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready      = (state == IDLE) && !rst;
  assign bus.avm_burstcount = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_write           <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_error      <= 1'b0;
      bus.rsp_readdata   <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_writedata  <= '0;
      bus.avm_byteenable <= '0;
    end else begin
      bus.rsp_valid <= (state_next == RESP);
      bus.rsp_error <= err_next;
      if (capture)       bus.rsp_readdata <= bus.avm_readdata;
      else if (err_next) bus.rsp_readdata <= '0;

      if (state == IDLE && bus.cmd_valid) begin
        is_write           <= bus.cmd_write;
        bus.avm_read       <= !bus.cmd_write;
        bus.avm_write      <= bus.cmd_write;
        bus.avm_address    <= bus.cmd_address & ~ADDRWIDTH'(BEW - 1);
        bus.avm_writedata  <= bus.cmd_writedata;
        bus.avm_byteenable <= bus.cmd_write ? bus.cmd_byteenable : '1;
      end else if (state == CMD && state_next != CMD) begin
        bus.avm_read  <= 1'b0;
        bus.avm_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_f2h_bridge_master.sv
// Directed bench for f2h_bridge_master; watchdog expectations follow F2H_TIMEOUT_EN.
module tb_f2h_bridge_master;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] bb_addr [3] = '{32'h0000_0104, 32'h0000_010F, 32'h0000_0110};
  logic [31:0] bb_aexp [3] = '{32'h0000_0100, 32'h0000_0108, 32'h0000_0110};
  logic [7:0]  bb_be   [3] = '{8'h0F, 8'h00, 8'hF0};
  logic [63:0] bb_data [3] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1001, 64'h0000_0000_0000_1002};

  f2h_bridge_master_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  f2h_bridge_master #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                     input logic [7:0] be);
    bus.cmd_valid      = 1'b1;
    bus.cmd_write      = wr;
    bus.cmd_address    = addr;
    bus.cmd_writedata  = data;
    bus.cmd_byteenable = be;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0;
    bus.cmd_writedata = '0; bus.cmd_byteenable = '0;
    bus.avm_readdata = '0; bus.avm_readdatavalid = 1'b0; bus.avm_waitrequest = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_readdata", bus.rsp_readdata, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_write", bus.avm_write, 0);
    chk("rst_avm_address", bus.avm_address, 0);
    chk("rst_avm_writedata", bus.avm_writedata, 0);
    chk("rst_avm_byteenable", bus.avm_byteenable, 0);
    chk("rst_burstcount", bus.avm_burstcount, 1);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write (cycle 0 = accept)
    chk("wr_ready_c0", bus.cmd_ready, 1);
    cmd(1'b1, 32'h0000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("wr_avm_write_c1", bus.avm_write, 1);
    chk("wr_avm_read_c1", bus.avm_read, 0);
    chk("wr_address_c1", bus.avm_address, 64'h10);
    chk("wr_writedata_c1", bus.avm_writedata, 64'hDEAD_BEEF_0123_4567);
    chk("wr_byteenable_c1", bus.avm_byteenable, 64'hFF);
    chk("wr_ready_c1", bus.cmd_ready, 0);
    chk("wr_rsp_valid_c1", bus.rsp_valid, 0);
    @(negedge clk);
    chk("wr_avm_write_c2", bus.avm_write, 0);
    chk("wr_rsp_valid_c2", bus.rsp_valid, 1);
    chk("wr_rsp_error_c2", bus.rsp_error, 0);
    @(negedge clk);
    chk("wr_rsp_valid_c3", bus.rsp_valid, 0);
    chk("wr_ready_c3", bus.cmd_ready, 1);
    chk("wr_readdata_unchanged", bus.rsp_readdata, 0);

    // Read with 3 stall cycles, data 2 cycles after release
    cmd(1'b0, 32'h0000_0013, 64'h0, 8'h00);
    bus.avm_waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("rd_avm_read_stall", bus.avm_read, 1);
      chk("rd_ready_low", bus.cmd_ready, 0);
      if (c == 4) bus.avm_waitrequest = 1'b0;
    end
    chk("rd_address", bus.avm_address, 64'h10);
    chk("rd_byteenable", bus.avm_byteenable, 64'hFF);
    @(negedge clk);
    chk("rd_avm_read_c5", bus.avm_read, 0);
    chk("rd_rsp_valid_c5", bus.rsp_valid, 0);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("rd_ready_c6", bus.cmd_ready, 0);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    chk("rd_rsp_valid_c7", bus.rsp_valid, 1);
    chk("rd_rsp_readdata", bus.rsp_readdata, 64'h1122_3344_5566_7788);
    chk("rd_rsp_error", bus.rsp_error, 0);
    chk("rd_ready_c7", bus.cmd_ready, 0);
    @(negedge clk);
    chk("rd_rsp_valid_c8", bus.rsp_valid, 0);
    chk("rd_ready_c8", bus.cmd_ready, 1);

    // Same-cycle grant and data
    cmd(1'b0, 32'h0000_0020, 64'h0, 8'h00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("sc_avm_read_c1", bus.avm_read, 1);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    chk("sc_rsp_valid_c2", bus.rsp_valid, 1);
    chk("sc_rsp_readdata", bus.rsp_readdata, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("sc_avm_read_c2", bus.avm_read, 0);
    @(negedge clk);
    chk("sc_ready_c3", bus.cmd_ready, 1);
    // Stray readdatavalid in IDLE must not disturb the held data
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    chk("stray_rsp_valid", bus.rsp_valid, 0);
    chk("stray_readdata_held", bus.rsp_readdata, 64'hA5A5_A5A5_A5A5_A5A5);

    // Back-to-back writes with cmd_valid held high; junk fields between accepts
    for (int c = 0; c < 10; c++) begin
      chk("bb_ready", bus.cmd_ready, (c % 3 == 0) ? 1 : 0);
      chk("bb_rsp_valid", bus.rsp_valid, (c % 3 == 2) ? 1 : 0);
      if (c % 3 == 1) begin
        chk("bb_avm_write", bus.avm_write, 1);
        chk("bb_address", bus.avm_address, bb_aexp[c / 3]);
        chk("bb_byteenable", bus.avm_byteenable, bb_be[c / 3]);
        chk("bb_writedata", bus.avm_writedata, bb_data[c / 3]);
      end
      if (c == 9)          bus.cmd_valid = 1'b0;
      else if (c % 3 == 0) cmd(1'b1, bb_addr[c / 3], bb_data[c / 3], bb_be[c / 3]);
      else                 cmd(1'b1, 32'h0000_BAD3, 64'hBADB_ADBA_DBAD_BADB, 8'h3C);
      @(negedge clk);
    end

    // Reset during RDWAIT, then a late readdatavalid
    cmd(1'b0, 32'h0000_0058, 64'h0, 8'h00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rr_avm_read_c1", bus.avm_read, 1);
    @(negedge clk);
    chk("rr_avm_read_c2", bus.avm_read, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_ready_in_rst", bus.cmd_ready, 0);
    chk("rr_avm_address", bus.avm_address, 0);
    chk("rr_rsp_readdata", bus.rsp_readdata, 0);
    chk("rr_rsp_valid_c3", bus.rsp_valid, 0);
    rst = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = 64'h0000_0000_0000_0077;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    chk("rr_rsp_valid_c4", bus.rsp_valid, 0);
    chk("rr_ready_c4", bus.cmd_ready, 1);
    chk("rr_readdata_c4", bus.rsp_readdata, 0);
    @(negedge clk);
    chk("rr_rsp_valid_c5", bus.rsp_valid, 0);

    // Slave that never releases waitrequest
    cmd(1'b0, 32'h0000_0044, 64'h0, 8'h00);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("to_avm_read_c1", bus.avm_read, 1);
    chk("to_address", bus.avm_address, 64'h40);
`ifdef F2H_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("to_avm_read_c16", bus.avm_read, 1);
    chk("to_rsp_valid_c16", bus.rsp_valid, 0);
    @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    chk("to_avm_read_c17", bus.avm_read, 0);
    chk("to_rsp_valid_c17", bus.rsp_valid, 1);
    chk("to_rsp_error_c17", bus.rsp_error, 1);
    chk("to_rsp_readdata_c17", bus.rsp_readdata, 0);
    @(negedge clk);
    chk("to_ready_c18", bus.cmd_ready, 1);
    chk("to_rsp_valid_c18", bus.rsp_valid, 0);
`else
    seen = 0;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("nto_avm_read_c100", bus.avm_read, 1);
    chk("nto_ready_c100", bus.cmd_ready, 0);
    chk("nto_no_rsp", 64'(seen), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("nto_ready_after_rst", bus.cmd_ready, 1);
    chk("nto_avm_read_after_rst", bus.avm_read, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
